cv32e40p_alu_ft_reconf: RTL and testbench

Reconfiguration controller that consumes the per-replica `alu_remove` pulses produced by the ALU permanent-fault monitors. It sits between the three monitors and the triplicated ALU datapath. It stalls issue, waits for in-flight ALU operations to drain, and then removes the faulty replica from the active mask. It acknowledges each removal back to its monitor and degrades the voting mode from TMR to DMR to simplex. If no healthy replica remains, it enters FAIL.

---
 rtl/cv32e40p_ft_pkg.sv | 30 +++
 rtl/cv32e40p_ft_prio_sel.sv | 17 +
 rtl/cv32e40p_alu_ft_reconf.sv | 139 +++++++++++++
 tb/tb_cv32e40p_alu_ft_reconf.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_ft_pkg.sv
// Shared definitions for the ALU fault-tolerance reconfiguration logic.
package cv32e40p_ft_pkg;

  localparam int FT_N_ALU = 3;

  localparam logic [1:0] FT_MODE_TMR     = 2'b00;
  localparam logic [1:0] FT_MODE_DMR     = 2'b01;
  localparam logic [1:0] FT_MODE_SIMPLEX = 2'b10;
  localparam logic [1:0] FT_MODE_FAIL    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_APPLY   = 2'd2,
    ST_FAIL    = 2'd3
  } alu_reconf_state_e;

  // Voting mode implied by the number of replicas still enabled.
  function automatic logic [1:0] ft_mode_from_mask(input logic [FT_N_ALU-1:0] mask);
    logic [1:0] mode;
    case ($countones(mask))
      3:       mode = FT_MODE_TMR;
      2:       mode = FT_MODE_DMR;
      1:       mode = FT_MODE_SIMPLEX;
      default: mode = FT_MODE_FAIL;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/cv32e40p_ft_prio_sel.sv
// Lowest-index-first one-hot selector with a valid flag.
module cv32e40p_ft_prio_sel #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_onehot,
  output logic         o_valid
);

  logic [N-1:0] w_neg;

  // Two's-complement trick isolates the lowest set bit.
  assign w_neg    = ~i_req + N'(1);
  assign o_onehot = i_req & w_neg;
  assign o_valid  = |i_req;

endmodule

// File: rtl/cv32e40p_alu_ft_reconf.sv
// Reconfiguration controller: drains the ALU and removes faulty replicas one
// at a time, degrading TMR -> DMR -> simplex -> FAIL.
module cv32e40p_alu_ft_reconf
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned QUIESCE_CYCLES = 2
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [FT_N_ALU-1:0] remove_req_i,
  input  logic                alu_busy_i,
  input  logic                clear_i,
  output logic [FT_N_ALU-1:0] alu_en_o,
  output logic [FT_N_ALU-1:0] remove_ack_o,
  output logic                stall_o,
  output logic [1:0]          mode_o,
  output logic                fatal_o
);

  localparam int CNT_W = $clog2(QUIESCE_CYCLES + 1);
  // Counter value on the last idle cycle needed before APPLY.
  localparam logic [CNT_W-1:0] QC_LAST = CNT_W'(QUIESCE_CYCLES - 1);

  alu_reconf_state_e   r_state, w_state_nxt;
  logic [FT_N_ALU-1:0] r_pend, w_pend_nxt;
  logic [FT_N_ALU-1:0] r_victim, w_victim_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [FT_N_ALU-1:0] r_alu_en, w_en_nxt;
  logic [FT_N_ALU-1:0] r_ack, w_ack_nxt;
  logic                r_stall, w_stall_nxt;
  logic [1:0]          r_mode, w_mode_nxt;
  logic                r_fatal, w_fatal_nxt;
  logic [FT_N_ALU-1:0] w_applied;
  logic [FT_N_ALU-1:0] w_sel_onehot;
  logic                w_sel_vld;
  logic                w_multi;

  cv32e40p_ft_prio_sel #(
    .N (FT_N_ALU)
  ) u_prio_sel (
    .i_req    (r_pend),
    .o_onehot (w_sel_onehot),
    .o_valid  (w_sel_vld)
  );

  assign w_multi = ($countones(r_alu_en) >= 2);

  // Next-state, pending-set and registered-output computation.
  always_comb begin
    w_state_nxt  = r_state;
    w_victim_nxt = r_victim;
    w_cnt_nxt    = '0;
    w_en_nxt     = r_alu_en;
    w_ack_nxt    = '0;
    w_fatal_nxt  = r_fatal;
    w_applied    = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_sel_vld) begin
          w_victim_nxt = w_sel_onehot;
          w_state_nxt  = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        // Any busy cycle restarts the drain window from zero.
        if (!alu_busy_i) begin
          if (r_cnt == QC_LAST) w_state_nxt = ST_APPLY;
          else                  w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_APPLY: begin
        w_applied = r_victim;
        w_ack_nxt = r_victim;
        if (w_multi) begin
          w_en_nxt    = r_alu_en & ~r_victim;
          w_state_nxt = ST_IDLE;
        end else begin
          // Last healthy replica: keep it driving, but flag the failure.
          w_fatal_nxt = 1'b1;
          w_state_nxt = ST_FAIL;
        end
      end
      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Requests for already-disabled replicas are dropped here.
    w_pend_nxt = (r_pend | (remove_req_i & r_alu_en)) & ~w_applied;

    if (clear_i) begin
      w_state_nxt = ST_IDLE;
      w_en_nxt    = '1;
      w_pend_nxt  = '0;
      w_fatal_nxt = 1'b0;
      w_cnt_nxt   = '0;
      w_ack_nxt   = '0;
    end

    w_stall_nxt = (w_state_nxt != ST_IDLE);
    w_mode_nxt  = (w_state_nxt == ST_FAIL) ? FT_MODE_FAIL : ft_mode_from_mask(w_en_nxt);
  end

  // State and output registers; all outputs come straight from flops.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pend   <= '0;
      r_victim <= '0;
      r_cnt    <= '0;
      r_alu_en <= '1;
      r_ack    <= '0;
      r_stall  <= 1'b0;
      r_mode   <= FT_MODE_TMR;
      r_fatal  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pend   <= w_pend_nxt;
      r_victim <= w_victim_nxt;
      r_cnt    <= w_cnt_nxt;
      r_alu_en <= w_en_nxt;
      r_ack    <= w_ack_nxt;
      r_stall  <= w_stall_nxt;
      r_mode   <= w_mode_nxt;
      r_fatal  <= w_fatal_nxt;
    end
  end

  assign alu_en_o     = r_alu_en;
  assign remove_ack_o = r_ack;
  assign stall_o      = r_stall;
  assign mode_o       = r_mode;
  assign fatal_o      = r_fatal;

endmodule

// File: tb/tb_cv32e40p_alu_ft_reconf.sv
// Randomized and directed bench for the ALU reconfiguration controller.
module tb_cv32e40p_alu_ft_reconf;

  localparam int Q = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_APPLY = 2;
  localparam int PH_FAIL  = 3;

  logic       clock;
  logic       rst_n;
  logic [2:0] remove_req_i;
  logic       alu_busy_i;
  logic       clear_i;
  logic [2:0] alu_en_o;
  logic [2:0] remove_ack_o;
  logic       stall_o;
  logic [1:0] mode_o;
  logic       fatal_o;

  int n_vec;
  int n_err;

  // Reference model state
  logic [2:0] m_mask;
  logic [2:0] m_pend;
  logic [2:0] m_ack;
  logic       m_fatal;
  int         m_phase;
  int         m_run;
  int         m_victim;

  cv32e40p_alu_ft_reconf #(
    .QUIESCE_CYCLES (Q)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .remove_req_i (remove_req_i),
    .alu_busy_i   (alu_busy_i),
    .clear_i      (clear_i),
    .alu_en_o     (alu_en_o),
    .remove_ack_o (remove_ack_o),
    .stall_o      (stall_o),
    .mode_o       (mode_o),
    .fatal_o      (fatal_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mask   = 3'b111;
    m_pend   = 3'b000;
    m_ack    = 3'b000;
    m_fatal  = 1'b0;
    m_phase  = PH_IDLE;
    m_run    = 0;
    m_victim = 0;
  endtask

  task automatic model_step(input logic [2:0] req, input logic busy, input logic clr);
    logic [2:0] applied;
    logic [2:0] mask_before;
    applied     = 3'b000;
    mask_before = m_mask;
    m_ack       = 3'b000;
    if (clr) begin
      m_mask  = 3'b111;
      m_pend  = 3'b000;
      m_fatal = 1'b0;
      m_phase = PH_IDLE;
      m_run   = 0;
    end else begin
      case (m_phase)
        PH_IDLE: begin
          if (m_pend != 3'b000) begin
            for (int i = 2; i >= 0; i--) if (m_pend[i]) m_victim = i;
            m_run   = 0;
            m_phase = PH_WAIT;
          end
        end
        PH_WAIT: begin
          m_run = busy ? 0 : m_run + 1;
          if (m_run == Q) m_phase = PH_APPLY;
        end
        PH_APPLY: begin
          applied = 3'b001 << m_victim;
          m_ack   = applied;
          if ($countones(m_mask) > 1) begin
            m_mask  = m_mask & ~applied;
            m_phase = PH_IDLE;
          end else begin
            m_fatal = 1'b1;
            m_phase = PH_FAIL;
          end
        end
        default: ;
      endcase
      m_pend = (m_pend | (req & mask_before)) & ~applied;
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [1:0] exp_mode;
    if (m_phase == PH_FAIL) exp_mode = 2'b11;
    else                    exp_mode = 2'(3 - $countones(m_mask));
    chk({ctx, ".en"},    32'(alu_en_o),     32'(m_mask));
    chk({ctx, ".ack"},   32'(remove_ack_o), 32'(m_ack));
    chk({ctx, ".stall"}, 32'(stall_o),      32'(m_phase != PH_IDLE));
    chk({ctx, ".mode"},  32'(mode_o),       32'(exp_mode));
    chk({ctx, ".fatal"}, 32'(fatal_o),      32'(m_fatal));
    chk({ctx, ".ack1h"}, 32'($countones(remove_ack_o) <= 1), 32'd1);
  endtask

  // One clock: drive inputs, step model on the edge, compare 1 time unit later.
  task automatic cycle(input string ctx, input logic [2:0] req, input logic busy, input logic clr);
    remove_req_i = req;
    alu_busy_i   = busy;
    clear_i      = clr;
    @(posedge clock);
    model_step(req, busy, clr);
    #1;
    check_outputs(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) cycle(ctx, 3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] busy_seq;
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    remove_req_i = 3'b000;
    alu_busy_i   = 1'b0;
    clear_i      = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    rst_n = 1'b1;

    idle("idle", 2);

    // Single removal of replica 1 with the ALU idle.
    cycle("rm1", 3'b010, 1'b0, 1'b0);
    idle("rm1", 6);

    // Replica 1 already disabled: request must be ignored.
    cycle("stale", 3'b010, 1'b0, 1'b0);
    idle("stale", 5);

    // Down to simplex, then remove the last replica.
    cycle("rm2", 3'b100, 1'b0, 1'b0);
    idle("rm2", 6);
    cycle("last", 3'b001, 1'b0, 1'b0);
    idle("last", 6);
    cycle("failreq", 3'b011, 1'b0, 1'b0);
    idle("fail", 3);
    cycle("clear", 3'b000, 1'b0, 1'b1);
    idle("clear", 2);

    // Busy interference during the drain window.
    cycle("busy", 3'b010, 1'b0, 1'b0);
    busy_seq = 3'b100;
    cycle("busy", 3'b000, 1'b0, 1'b0);
    for (int i = 2; i >= 0; i--) cycle("busy", 3'b000, busy_seq[i], 1'b0);
    idle("busy", 6);
    cycle("clr2", 3'b000, 1'b0, 1'b1);

    // Two simultaneous requests, serviced lowest index first.
    cycle("dual", 3'b101, 1'b0, 1'b0);
    idle("dual", 12);
    cycle("clr3", 3'b000, 1'b0, 1'b1);

    // Asynchronous reset while quiescing.
    cycle("rstq", 3'b001, 1'b0, 1'b0);
    idle("rstq", 2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rstq.async");
    #1;
    rst_n = 1'b1;
    idle("rstq.after", 6);

    // Request coinciding with clear is discarded.
    cycle("clrreq", 3'b010, 1'b0, 1'b1);
    idle("clrreq", 5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] r;
      logic       b;
      logic       c;
      r = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      b = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 149) == 0);
      cycle("rand", r, b, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
